// File: rtl/int_sequencer_if.sv
// -----------------------------------------------------------------------------
// int_sequencer_if
// Bundles the interrupt-controller handshake and the PC/fetch-stage signals
// seen by int_sequencer.
//   slave  : sequencer view (takes requests and pipeline status, drives the
//            flush/redirect controls and status registers)
//   master : environment view (interrupt controller + pipeline)
// Signals:
//   intCPU, intID      interrupt request level and its ID
//   intDisabled        back-pressure to the controller (1 = do not raise)
//   mask               software global interrupt mask
//   pc_boundary        pipeline at an instruction boundary
//   pc_current         PC of the next instruction (return address)
//   reti               one-cycle pulse, reti retiring
//   flush, redirect    fetch stall / one-cycle PC load strobe
//   redirect_pc        PC target while redirect is high
//   int_active         high while the handler runs
//   int_id_reg         ID of the interrupt being or last serviced
//   saved_pc           return address captured on entry
//   int_count          number of entries taken, wraps at 16 bits
// -----------------------------------------------------------------------------
interface int_sequencer_if #(
   parameter int PC_W = 27,
   parameter int ID_W = 8
);
   logic            intCPU;
   logic [ID_W-1:0] intID;
   logic            intDisabled;
   logic            mask;
   logic            pc_boundary;
   logic [PC_W-1:0] pc_current;
   logic            reti;
   logic            flush;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            int_active;
   logic [ID_W-1:0] int_id_reg;
   logic [PC_W-1:0] saved_pc;
   logic [15:0]     int_count;

   modport slave (
      input  intCPU, intID, mask, pc_boundary, pc_current, reti,
      output intDisabled, flush, redirect, redirect_pc, int_active,
             int_id_reg, saved_pc, int_count
   );

   modport master (
      output intCPU, intID, mask, pc_boundary, pc_current, reti,
      input  intDisabled, flush, redirect, redirect_pc, int_active,
             int_id_reg, saved_pc, int_count
   );
endinterface

// File: rtl/int_sequencer.sv
// -----------------------------------------------------------------------------
// int_sequencer
// CPU-side responder to the interrupt controller. Accepts a request, waits
// for an instruction boundary while flushing, saves the return PC and
// redirects fetch to INT_VECTOR. On reti it redirects back to the saved PC
// and keeps intDisabled high until one instruction of the interrupted
// program has reached a boundary, so back-to-back interrupts cannot starve
// the interrupted code.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      int_sequencer_if.slave (handshake, pipeline status, outputs)
// Parameters:
//   PC_W, ID_W   PC and interrupt-ID widths (must match the interface)
//   INT_VECTOR   PC loaded on interrupt entry
//   COUNT_INIT   reset value of int_count (0 in normal use)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module int_sequencer #(
   parameter int              PC_W       = 27,
   parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(1),
   parameter int              ID_W       = 8,
   parameter logic [15:0]     COUNT_INIT = 16'd0
) (
   input  logic            clk,
   input  logic            reset_n,
   int_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BND = 2'd1,
      ISR      = 2'd2,
      GUARD    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            dis_q, dis_d;
   logic            flush_q, flush_d;
   logic            redir_q, redir_d;
   logic [PC_W-1:0] rpc_q, rpc_d;
   logic            act_q, act_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [PC_W-1:0] spc_q, spc_d;
   logic [15:0]     cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dis_q   <= 1'b1;
         flush_q <= 1'b0;
         redir_q <= 1'b0;
         rpc_q   <= '0;
         act_q   <= 1'b0;
         id_q    <= '0;
         spc_q   <= '0;
         cnt_q   <= COUNT_INIT;
      end else begin
         state_q <= state_d;
         dis_q   <= dis_d;
         flush_q <= flush_d;
         redir_q <= redir_d;
         rpc_q   <= rpc_d;
         act_q   <= act_d;
         id_q    <= id_d;
         spc_q   <= spc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dis_d   = dis_q;
      flush_d = flush_q;
      redir_d = 1'b0;            // redirect is always a single-cycle strobe
      rpc_d   = rpc_q;
      act_d   = act_q;
      id_d    = id_q;
      spc_d   = spc_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            // Controller sees the live mask while idle.
            dis_d = bus.mask;
            if (bus.intCPU && !bus.mask) begin
               id_d    = bus.intID;
               dis_d   = 1'b1;
               flush_d = 1'b1;
               state_d = WAIT_BND;
            end
         end
         WAIT_BND: begin
            if (bus.pc_boundary) begin
               spc_d   = bus.pc_current;
               redir_d = 1'b1;
               rpc_d   = INT_VECTOR;
               flush_d = 1'b0;
               act_d   = 1'b1;
               cnt_d   = cnt_q + 16'd1;
               state_d = ISR;
            end
         end
         ISR: begin
            // Requests are not nested; pc_boundary is irrelevant here, so
            // reti always wins a same-cycle collision.
            if (bus.reti) begin
               redir_d = 1'b1;
               rpc_d   = spc_q;
               act_d   = 1'b0;
               state_d = GUARD;
            end
         end
         GUARD: begin
            // The boundary seen alongside our own redirect belongs to the
            // handler; wait for the next one, which retires an instruction
            // of the interrupted program.
            if (bus.pc_boundary && !redir_q) begin
               dis_d   = bus.mask;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.intDisabled = dis_q;
   assign bus.flush       = flush_q;
   assign bus.redirect    = redir_q;
   assign bus.redirect_pc = rpc_q;
   assign bus.int_active  = act_q;
   assign bus.int_id_reg  = id_q;
   assign bus.saved_pc    = spc_q;
   assign bus.int_count   = cnt_q;

endmodule

// File: tb/tb_int_sequencer.sv
// -----------------------------------------------------------------------------
// tb_int_sequencer
// Directed bench for int_sequencer. A second instance with int_count
// starting at 0xFFFE shares the same stimulus so the 16-bit wrap is seen
// after two entries.
// -----------------------------------------------------------------------------
module tb_int_sequencer;
   localparam int PC_W = 27;
   localparam int ID_W = 8;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_err;

   int_sequencer_if #(.PC_W(PC_W), .ID_W(ID_W)) bus ();
   int_sequencer_if #(.PC_W(PC_W), .ID_W(ID_W)) bus2 ();

   int_sequencer #(.PC_W(PC_W), .INT_VECTOR(27'd1), .ID_W(ID_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int_sequencer #(.PC_W(PC_W), .INT_VECTOR(27'd1), .ID_W(ID_W),
                   .COUNT_INIT(16'hFFFE)) dut_wrap (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus2)
   );

   assign bus2.intCPU      = bus.intCPU;
   assign bus2.intID       = bus.intID;
   assign bus2.mask        = bus.mask;
   assign bus2.pc_boundary = bus.pc_boundary;
   assign bus2.pc_current  = bus.pc_current;
   assign bus2.reti        = bus.reti;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".dis"},   32'(bus.intDisabled), 32'd1);
      chk({tag, ".flush"}, 32'(bus.flush),       32'd0);
      chk({tag, ".redir"}, 32'(bus.redirect),    32'd0);
      chk({tag, ".act"},   32'(bus.int_active),  32'd0);
      chk({tag, ".rpc"},   32'(bus.redirect_pc), 32'd0);
      chk({tag, ".spc"},   32'(bus.saved_pc),    32'd0);
      chk({tag, ".id"},    32'(bus.int_id_reg),  32'd0);
      chk({tag, ".cnt"},   32'(bus.int_count),   32'd0);
      chk({tag, ".cnt2"},  32'(bus2.int_count),  32'hFFFE);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset_n         = 1'b0;
      bus.intCPU      = 1'b0;
      bus.intID       = '0;
      bus.mask        = 1'b0;
      bus.pc_boundary = 1'b0;
      bus.pc_current  = '0;
      bus.reti        = 1'b0;
      #12;
      chk_reset("rst");

      // Request and boundary both present right out of reset.
      bus.intCPU      = 1'b1;
      bus.intID       = 8'd3;
      bus.pc_current  = 27'h0000100;
      bus.pc_boundary = 1'b1;
      #10 reset_n = 1'b1;
      step();
      chk("acc.flush", 32'(bus.flush),       32'd1);
      chk("acc.dis",   32'(bus.intDisabled), 32'd1);
      chk("acc.id",    32'(bus.int_id_reg),  32'd3);
      chk("acc.redir", 32'(bus.redirect),    32'd0);
      bus.intCPU = 1'b0;
      step();
      chk("ent.redir", 32'(bus.redirect),    32'd1);
      chk("ent.rpc",   32'(bus.redirect_pc), 32'd1);
      chk("ent.spc",   32'(bus.saved_pc),    32'h100);
      chk("ent.cnt",   32'(bus.int_count),   32'd1);
      chk("ent.cnt2",  32'(bus2.int_count),  32'hFFFF);
      chk("ent.act",   32'(bus.int_active),  32'd1);
      chk("ent.flush", 32'(bus.flush),       32'd0);
      chk("ent.dis",   32'(bus.intDisabled), 32'd1);
      bus.pc_boundary = 1'b0;
      step();
      chk("isr.redir", 32'(bus.redirect),    32'd0);
      chk("isr.act",   32'(bus.int_active),  32'd1);

      // Nested request in ISR is ignored.
      bus.intCPU = 1'b1;
      bus.intID  = 8'd7;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("nest.id",    32'(bus.int_id_reg), 32'd3);
         chk("nest.redir", 32'(bus.redirect),   32'd0);
      end
      bus.intCPU = 1'b0;

      // reti together with pc_boundary: reti wins.
      bus.reti        = 1'b1;
      bus.pc_boundary = 1'b1;
      step();
      chk("ret.redir", 32'(bus.redirect),    32'd1);
      chk("ret.rpc",   32'(bus.redirect_pc), 32'h100);
      chk("ret.act",   32'(bus.int_active),  32'd0);
      chk("ret.dis",   32'(bus.intDisabled), 32'd1);
      bus.reti = 1'b0;
      step();   // boundary during the redirect cycle does not count
      chk("grd.redir", 32'(bus.redirect),    32'd0);
      chk("grd.dis",   32'(bus.intDisabled), 32'd1);
      step();
      chk("grd.exit",  32'(bus.intDisabled), 32'd0);
      bus.pc_boundary = 1'b0;

      // reti in IDLE does nothing.
      bus.reti = 1'b1;
      step();
      chk("ireti.redir", 32'(bus.redirect),    32'd0);
      chk("ireti.dis",   32'(bus.intDisabled), 32'd0);
      bus.reti = 1'b0;

      // Masked request is ignored.
      bus.mask   = 1'b1;
      bus.intCPU = 1'b1;
      bus.intID  = 8'd5;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("msk.flush", 32'(bus.flush),       32'd0);
         chk("msk.redir", 32'(bus.redirect),    32'd0);
         chk("msk.dis",   32'(bus.intDisabled), 32'd1);
      end
      chk("msk.cnt", 32'(bus.int_count),  32'd1);
      chk("msk.id",  32'(bus.int_id_reg), 32'd3);
      bus.mask = 1'b0;
      step();
      chk("unm.flush", 32'(bus.flush),      32'd1);
      chk("unm.id",    32'(bus.int_id_reg), 32'd5);
      bus.intCPU = 1'b0;

      // No boundary for 10 cycles: keep flushing, no redirect.
      for (int i = 0; i < 10; i++) begin
         step();
         chk("wb.flush", 32'(bus.flush),    32'd1);
         chk("wb.redir", 32'(bus.redirect), 32'd0);
      end
      bus.pc_current  = 27'h00002AB;
      bus.pc_boundary = 1'b1;
      step();
      chk("ent2.redir", 32'(bus.redirect),   32'd1);
      chk("ent2.flush", 32'(bus.flush),      32'd0);
      chk("ent2.spc",   32'(bus.saved_pc),   32'h2AB);
      chk("ent2.cnt",   32'(bus.int_count),  32'd2);
      chk("ent2.wrap",  32'(bus2.int_count), 32'd0);
      bus.pc_boundary = 1'b0;

      // Return, then take a third request and reset while in WAIT_BND.
      bus.reti = 1'b1;
      step();
      chk("ret2.rpc", 32'(bus.redirect_pc), 32'h2AB);
      bus.reti        = 1'b0;
      bus.pc_boundary = 1'b1;
      step();
      step();
      chk("grd2.exit", 32'(bus.intDisabled), 32'd0);
      bus.pc_boundary = 1'b0;
      bus.intCPU      = 1'b1;
      bus.intID       = 8'd9;
      step();
      chk("acc3.flush", 32'(bus.flush),      32'd1);
      chk("acc3.id",    32'(bus.int_id_reg), 32'd9);
      bus.intCPU = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      chk_reset("arst");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
